// File: rtl/instr_ram_uart_dump.sv
// instr_ram_uart_dump
// Reads the instruction RAM back from address 0 and sends each byte out
// as an 8N1 UART frame, LSB first. The dump stops at the first TERMINATOR
// byte (which is not sent) or after MAX_ADDRESS, and finishes with END_BYTE.
// The MCU uses this to check what it loaded before the RAM is switched over.
//
// Ports:
//   clk         system clock
//   rst         synchronous reset, active low
//   start       dump request, only looked at while idle
//   ram_addr    RAM read address (synchronous RAM, data one cycle later)
//   ram_data    RAM read data, sampled only in LATCH
//   tx          UART serial line, idle high, registered
//   busy        high from the cycle after start is accepted until done
//   done        one-cycle pulse as the END_BYTE stop bit completes
//   byte_count  program bytes sent in the current/last dump (END_BYTE excluded)
//   dbg_state   current FSM state, for observation only
//
// Handshake: start is a request level. It is accepted on the first clock
// edge where it is high while the block is idle; busy then goes high and
// further start requests are ignored until the single-cycle done pulse,
// after which the block is idle again.
module instr_ram_uart_dump #(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    MAX_ADDRESS  = 255,
  parameter int                    CLKS_PER_BIT = 434,
  parameter logic [DATA_WIDTH-1:0] TERMINATOR   = 8'h00,
  parameter logic [DATA_WIDTH-1:0] END_BYTE     = 8'h0A
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  tx,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   byte_count,
  output logic [2:0]            dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LATCH     = 3'd2,
    START_BIT = 3'd3,
    DATA_BITS = 3'd4,
    STOP_BIT  = 3'd5,
    DONE      = 3'd6
  } state_t;

  state_t                state_q,      state_d;
  logic [CNT_W-1:0]      baud_q,       baud_d;
  logic [2:0]            bit_idx_q,    bit_idx_d;
  logic [DATA_WIDTH-1:0] shift_q,      shift_d;
  logic                  last_q,       last_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q,   ram_addr_d;
  logic [ADDR_WIDTH:0]   byte_count_q, byte_count_d;
  logic                  busy_q,       busy_d;
  logic                  done_q,       done_d;
  logic                  tx_q,         tx_d;

  logic baud_end;
  assign baud_end = (baud_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    last_d       = last_q;
    ram_addr_d   = ram_addr_q;
    byte_count_d = byte_count_q;
    busy_d       = busy_q;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (start) begin
          ram_addr_d   = '0;
          byte_count_d = '0;
          last_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = FETCH;
        end
      end
      // One cycle for the synchronous RAM to return the addressed word.
      FETCH: begin
        baud_d  = '0;
        state_d = LATCH;
      end
      LATCH: begin
        baud_d = '0;
        if (ram_data == TERMINATOR) begin
          shift_d = END_BYTE;
          last_d  = 1'b1;
        end else begin
          shift_d = ram_data;
        end
        state_d = START_BIT;
      end
      START_BIT: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) state_d = STOP_BIT;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      STOP_BIT: begin
        if (baud_end) begin
          baud_d = '0;
          if (last_q) begin
            state_d = DONE;
          end else begin
            byte_count_d = byte_count_q + (ADDR_WIDTH+1)'(1);
            // Last address reached without a terminator: go straight to
            // END_BYTE, holding the address rather than wrapping.
            if (ram_addr_q == ADDR_WIDTH'(MAX_ADDRESS)) begin
              shift_d = END_BYTE;
              last_d  = 1'b1;
              state_d = START_BIT;
            end else begin
              ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
              state_d    = FETCH;
            end
          end
        end
      end
      DONE: begin
        baud_d  = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

    // Outputs are computed from the next state so they change on the same
    // edge as the state and every bit lasts exactly CLKS_PER_BIT cycles.
    done_d = (state_d == DONE);
    unique case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA_BITS: tx_d = shift_d[bit_idx_d];
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      last_q       <= 1'b0;
      ram_addr_q   <= '0;
      byte_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      last_q       <= last_d;
      ram_addr_q   <= ram_addr_d;
      byte_count_q <= byte_count_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tx_q         <= tx_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign byte_count = byte_count_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tx         = tx_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_instr_ram_uart_dump.sv
// Bench for instr_ram_uart_dump with CLKS_PER_BIT=4. Two instances: dut0
// with the full address range, dut1 with MAX_ADDRESS=3 for the no-terminator
// case. A UART decoder per instance pops the expected queue on every byte.
module tb_instr_ram_uart_dump;
  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0;
  logic [7:0] ram_addr0, ram_data0, ram_addr1, ram_data1;
  logic       tx0, busy0, done0, tx1, busy1, done1;
  logic [8:0] bc0, bc1;
  logic [2:0] st0, st1;
  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];

  always @(posedge clk) ram_data0 <= mem0[ram_addr0];
  always @(posedge clk) ram_data1 <= mem1[ram_addr1];

  instr_ram_uart_dump #(.CLKS_PER_BIT(CPB)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .ram_addr(ram_addr0),
    .ram_data(ram_data0), .tx(tx0), .busy(busy0), .done(done0),
    .byte_count(bc0), .dbg_state(st0)
  );

  instr_ram_uart_dump #(.CLKS_PER_BIT(CPB), .MAX_ADDRESS(3)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .ram_addr(ram_addr1),
    .ram_data(ram_data1), .tx(tx1), .busy(busy1), .done(done1),
    .byte_count(bc1), .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_full_q[$];
  int   done_cnt0 = 0, done_cnt1 = 0, busy_cyc0 = 0;
  logic addr1_over = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic got_byte(input int i, input logic [7:0] b);
    if (i == 0) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_byte0: got %0h expected none", b);
      end else check("rx_byte0", b, exp_q.pop_front());
    end else begin
      if (exp_full_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_byte1: got %0h expected none", b);
      end else check("rx_byte1", b, exp_full_q.pop_front());
    end
  endtask

  // ---------------- monitor / UART decoders ----------------
  logic       rx_act [2];
  int         rx_cnt [2];
  logic [7:0] rx_sh  [2];

  always @(negedge clk) begin
    logic t;
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    if (busy0) busy_cyc0++;
    if (ram_addr1 > 8'd3) addr1_over = 1'b1;
    for (int i = 0; i < 2; i++) begin
      t = (i == 0) ? tx0 : tx1;
      if (!rst) rx_act[i] = 1'b0;
      else if (!rx_act[i]) begin
        if (!t) begin
          rx_act[i] = 1'b1;
          rx_cnt[i] = 0;
        end
      end else begin
        rx_cnt[i]++;
        // Samples land mid-bit: data bit k at cycle CPB*(k+1)+CPB/2.
        if (rx_cnt[i] >= 6 && rx_cnt[i] <= 34 && (rx_cnt[i] - 6) % CPB == 0)
          rx_sh[i] = {t, rx_sh[i][7:1]};
        else if (rx_cnt[i] == 38) begin
          check((i == 0) ? "stop_bit0" : "stop_bit1", {31'd0, t}, 32'd1);
          rx_act[i] = 1'b0;
          got_byte(i, rx_sh[i]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_basic();
    mem0[0] = 8'h4A; mem0[1] = 8'h24; mem0[2] = 8'h4B; mem0[3] = 8'h24; mem0[4] = 8'h00;
  endtask

  task automatic push_basic();
    exp_q.push_back(8'h4A); exp_q.push_back(8'h24); exp_q.push_back(8'h4B);
    exp_q.push_back(8'h24); exp_q.push_back(8'h0A);
  endtask

  // Pulse start on dut0, check the 3-cycle latency to the start bit, then
  // wait (bounded) for done and check final state. restart_at>0 re-asserts
  // start for 3 cycles that many cycles after tx falls.
  task automatic run0(input int restart_at, input int exp_cyc, input int exp_bc, input int exp_addr);
    int cyc;
    done_cnt0 = 0;
    busy_cyc0 = 0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("busy_rise", {31'd0, busy0}, 32'd1);
    check("tx_fetch", {31'd0, tx0}, 32'd1);
    @(negedge clk);
    check("tx_latch", {31'd0, tx0}, 32'd1);
    @(negedge clk);
    check("tx_fall", {31'd0, tx0}, 32'd0);
    cyc = 0;
    while (!done0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (restart_at > 0 && cyc == restart_at) start0 = 1'b1;
      if (restart_at > 0 && cyc == restart_at + 3) start0 = 1'b0;
    end
    check("done_seen", {31'd0, done0}, 32'd1);
    check("done_time", cyc, exp_cyc);
    @(negedge clk);
    check("done_width", {31'd0, done0}, 32'd0);
    check("busy_fall", {31'd0, busy0}, 32'd0);
    check("byte_count", {23'd0, bc0}, exp_bc);
    check("ram_addr", {24'd0, ram_addr0}, exp_addr);
    check("done_pulses", done_cnt0, 1);
    check("exp_drained", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'h5A;
      mem1[i] = 8'h55;
    end

    // Reset held with start high: nothing may start.
    rst = 1'b0; start0 = 1'b1; start1 = 1'b1;
    tick(3);
    check("rst_tx", {31'd0, tx0}, 32'd1);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_addr", {24'd0, ram_addr0}, 32'd0);
    check("rst_bc", {23'd0, bc0}, 32'd0);
    check("rst_tx1", {31'd0, tx1}, 32'd1);
    start0 = 1'b0; start1 = 1'b0; rst = 1'b1;
    tick(6);
    check("idle_tx", {31'd0, tx0}, 32'd1);
    check("idle_busy", {31'd0, busy0}, 32'd0);

    // Basic dump: 5 frames of 40 cycles plus 4 two-cycle gaps = 208.
    load_basic();
    push_basic();
    run0(0, 208, 4, 4);
    tick(3);

    // Start re-asserted during frame 2 must be ignored.
    push_basic();
    run0(50, 208, 4, 4);
    tick(3);

    // Empty program: only END_BYTE, busy for 2+40+1 cycles.
    mem0[0] = 8'h00;
    exp_q.push_back(8'h0A);
    run0(0, 40, 0, 0);
    check("empty_busy_cycles", busy_cyc0, 43);
    tick(3);

    // Full RAM on dut1: 4 frames, 3 gaps, END_BYTE with no gap = 206.
    mem1[0] = 8'h11; mem1[1] = 8'h22; mem1[2] = 8'h33; mem1[3] = 8'h44;
    exp_full_q.push_back(8'h11); exp_full_q.push_back(8'h22);
    exp_full_q.push_back(8'h33); exp_full_q.push_back(8'h44);
    exp_full_q.push_back(8'h0A);
    done_cnt1 = 0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    tick(2);
    check("full_tx_fall", {31'd0, tx1}, 32'd0);
    cyc = 0;
    while (!done1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("full_done_seen", {31'd0, done1}, 32'd1);
    check("full_done_time", cyc, 206);
    @(negedge clk);
    check("full_busy", {31'd0, busy1}, 32'd0);
    check("full_bc", {23'd0, bc1}, 32'd4);
    check("full_addr", {24'd0, ram_addr1}, 32'd3);
    check("full_no_wrap", {31'd0, addr1_over}, 32'd0);
    check("full_pulses", done_cnt1, 1);
    check("full_drained", exp_full_q.size(), 0);
    tick(3);

    // Reset in the middle of frame 1's data bits, then a clean dump.
    load_basic();
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    tick(2 + 12);
    check("mid_busy_before", {31'd0, busy0}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_tx", {31'd0, tx0}, 32'd1);
    check("mid_rst_busy", {31'd0, busy0}, 32'd0);
    check("mid_rst_state", {29'd0, st0}, 32'd0);
    check("mid_rst_bc", {23'd0, bc0}, 32'd0);
    rst = 1'b1;
    tick(3);
    push_basic();
    run0(0, 208, 4, 4);
    tick(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
